// File: rtl/bmc_pkg.sv
// Shared constants and helper functions for the soft-decision branch metric unit
// and the models that check it.
package bmc_pkg;

  localparam int MAX_N_OUT = 4;

  function automatic int smax_f(input int sw);
    return (1 << sw) - 1;
  endfunction

  function automatic int mw_f(input int n_out, input int sw);
    return $clog2(n_out * smax_f(sw) + 1);
  endfunction

  // Metric of hypothesis h: every transmitted output j costs its distance
  // from the confident level that h predicts for it.
  function automatic int hyp_metric(input int n_out, input int sw,
                                    input logic [MAX_N_OUT-1:0] mask,
                                    input logic [31:0] samples, input int h);
    int acc;
    int s;
    acc = 0;
    for (int j = 0; j < MAX_N_OUT; j++) begin
      if (j < n_out && mask[j]) begin
        s = int'((samples >> (j * sw)) & 32'(smax_f(sw)));
        acc += h[j] ? smax_f(sw) - s : s;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/bmc_pipe_stage.sv
// One elastic valid/ready register slice; loads when empty or when its content
// leaves in the same cycle.
module bmc_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      // NOTE: the payload is reset too, so downstream reads zeros rather than
      // stale metrics after a reset.
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end

endmodule

// File: rtl/bmc_soft.sv
// Soft-decision branch metric unit: per-symbol puncture masking (S1) followed by
// metric summation for all 2^N_OUT hypotheses (S2).
module bmc_soft
  import bmc_pkg::*;
#(
  parameter  int N_OUT     = 2,
  parameter  int SW        = 3,
  parameter  int PUNCT_LEN = 4,
  localparam int MW        = mw_f(N_OUT, SW)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_OUT*SW-1:0]           rx_soft,
  input  logic                          frame_start,
  input  logic                          punct_en,
  input  logic [PUNCT_LEN*N_OUT-1:0]    punct_pattern,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(2**N_OUT)*MW-1:0]      bm,
  output logic                          out_erased
);

  localparam int SMAX = smax_f(SW);
  localparam int NH   = 1 << N_OUT;
  localparam int PW   = (PUNCT_LEN > 1) ? $clog2(PUNCT_LEN) : 1;

  typedef struct packed {
    logic                     erased;
    logic [N_OUT-1:0][SW-1:0] d1;
    logic [N_OUT-1:0][SW-1:0] d0;
  } s1_t;

  typedef struct packed {
    logic                  erased;
    logic [NH-1:0][MW-1:0] bm;
  } s2_t;

  logic [PW-1:0]            phase;
  logic [PW-1:0]            use_phase;
  logic [N_OUT-1:0]         mask;
  logic [N_OUT-1:0][SW-1:0] rx_arr;
  logic                     accept;
  logic                     s1_in_ready, s1_valid, s2_in_ready, s2_valid;
  s1_t                      s1_d, s1_q;
  s2_t                      s2_d, s2_q;

  assign rx_arr    = rx_soft;
  assign in_ready  = s1_in_ready && !rst;
  assign accept    = in_valid && in_ready;
  assign use_phase = frame_start ? '0 : phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (accept) begin
      // NOTE: non-blocking so every register in this edge sees the old phase.
      phase <= (use_phase == PW'(PUNCT_LEN - 1)) ? '0 : use_phase + PW'(1);
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    mask = punct_en ? N_OUT'(punct_pattern >> (int'(use_phase) * N_OUT)) : '1;
    s1_d = '0;
    for (int j = 0; j < N_OUT; j++) begin
      if (mask[j]) begin
        s1_d.d0[j] = rx_arr[j];
        s1_d.d1[j] = SW'(SMAX) - rx_arr[j];
      end
    end
    s1_d.erased = (mask == '0);
  end

  always_comb begin
    logic [MW-1:0] acc;
    acc  = '0;
    s2_d = '0;
    for (int h = 0; h < NH; h++) begin
      acc = '0;
      for (int j = 0; j < N_OUT; j++) begin
        acc = acc + MW'(h[j] ? s1_q.d1[j] : s1_q.d0[j]);
      end
      s2_d.bm[h] = acc;
    end
    s2_d.erased = s1_q.erased;
  end

  bmc_pipe_stage #(.W($bits(s1_t))) u_s1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (s1_in_ready),
    .in_data   (s1_d),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .out_data  (s1_q)
  );

  bmc_pipe_stage #(.W($bits(s2_t))) u_s2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .in_data   (s2_d),
    .out_valid (s2_valid),
    .out_ready (out_ready),
    .out_data  (s2_q)
  );

  assign out_valid  = s2_valid && !rst;
  assign bm         = s2_q.bm;
  assign out_erased = s2_q.erased;

endmodule

// File: tb/tb_bmc_soft.sv
// Self-checking bench for bmc_soft (N_OUT=2, SW=3, PUNCT_LEN=2) against an
// in-order scoreboard fed by a distance-based reference model.
module tb_bmc_soft;

  localparam int SMAX = 7;
  localparam int PL   = 2;
  localparam logic [5:0] SYM = {3'd7, 3'd0};

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  rx_soft;
  logic        frame_start;
  logic        punct_en;
  logic [3:0]  punct_pattern;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] bm;
  logic        out_erased;

  int          errors = 0;
  int          checks = 0;
  int          n_acc  = 0;
  int          ph_m   = 0;
  logic [16:0] exp_q[$];
  logic [16:0] out_log[$];
  logic        stall_prev = 1'b0;
  logic [15:0] stall_bm;
  logic        stall_er;

  always #5 clk = ~clk;

  bmc_soft #(.N_OUT(2), .SW(3), .PUNCT_LEN(PL)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .rx_soft       (rx_soft),
    .frame_start   (frame_start),
    .punct_en      (punct_en),
    .punct_pattern (punct_pattern),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .bm            (bm),
    .out_erased    (out_erased)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each hypothesis predicts a confident level per output; a transmitted output
  // costs its distance to that level, a punctured one costs nothing.
  function automatic logic [16:0] model(input logic [5:0] rx, input logic [1:0] m);
    logic [15:0] r;
    int sum, s;
    r = '0;
    for (int h = 0; h < 4; h++) begin
      sum = 0;
      for (int j = 0; j < 2; j++) begin
        if (m[j]) begin
          s = int'(rx >> (3 * j)) & 7;
          sum += ((h >> j) & 1) ? SMAX - s : s;
        end
      end
      r[h*4 +: 4] = 4'(sum);
    end
    return {m == 2'b00, r};
  endfunction

  task automatic step(input logic iv, input logic fs, input logic [5:0] rx, input logic ordy);
    logic [16:0] e;
    logic [1:0]  m;
    int          use_ph;
    @(negedge clk);
    in_valid = iv; frame_start = fs; rx_soft = rx; out_ready = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || ordy));
    if (stall_prev) begin
      check("stall_bm", 32'(bm), 32'(stall_bm));
      check("stall_erased", 32'(out_erased), 32'(stall_er));
      check("stall_valid", 32'(out_valid), 32'd1);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
      else begin
        e = exp_q.pop_front();
        check("bm", 32'(bm), 32'(e[15:0]));
        check("out_erased", 32'(out_erased), 32'(e[16]));
        out_log.push_back({out_erased, bm});
      end
    end
    stall_prev = out_valid && !out_ready;
    stall_bm   = bm;
    stall_er   = out_erased;
    if (in_valid && in_ready) begin
      use_ph = fs ? 0 : ph_m;
      m      = punct_en ? 2'(punct_pattern >> (use_ph * 2)) : 2'b11;
      exp_q.push_back(model(rx, m));
      ph_m = (use_ph + 1) % PL;
      n_acc++;
    end
    @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      step(1'b0, 1'b0, 6'd0, 1'b1);
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    #1;
    check("drain_idle", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int start;
    rst = 1'b1; in_valid = 1'b0; frame_start = 1'b0; rx_soft = '0;
    out_ready = 1'b0; punct_en = 1'b0; punct_pattern = {2'b01, 2'b11};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bm", 32'(bm), 32'd0);
    check("rst_erased", 32'(out_erased), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic, no puncturing, with the two-cycle latency checked explicitly.
    step(1'b1, 1'b0, SYM, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("lat_edge1", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    check("lat_edge2", 32'(out_valid), 32'd1);
    check("basic_bm", 32'(bm), 32'h70E7);
    check("basic_erased", 32'(out_erased), 32'd0);
    drain();

    // Puncturing: phase 0 keeps both outputs, phase 1 keeps output 0 only.
    punct_en = 1'b1;
    out_log.delete();
    step(1'b1, 1'b1, SYM, 1'b1);
    step(1'b1, 1'b0, SYM, 1'b1);
    step(1'b1, 1'b0, SYM, 1'b1);
    drain();
    check("punct_first", 32'(out_log[0][15:0]), 32'h70E7);
    check("punct_second", 32'(out_log[1][15:0]), 32'h7070);
    check("punct_wrap", 32'(out_log[2][15:0]), 32'h70E7);

    // frame_start on the 2nd symbol of a stream, and once without in_valid.
    out_log.delete();
    step(1'b1, 1'b0, SYM, 1'b1);
    step(1'b0, 1'b1, SYM, 1'b1);
    step(1'b1, 1'b0, SYM, 1'b1);
    step(1'b1, 1'b1, SYM, 1'b1);
    step(1'b1, 1'b0, SYM, 1'b1);
    drain();
    check("fs_pre", 32'(out_log[0][15:0]), 32'h7070);
    check("fs_sym1", 32'(out_log[1][15:0]), 32'h70E7);
    check("fs_sym2", 32'(out_log[2][15:0]), 32'h70E7);
    check("fs_sym3", 32'(out_log[3][15:0]), 32'h7070);

    // Full erasure at phase 0.
    punct_pattern = {2'b11, 2'b00};
    out_log.delete();
    step(1'b1, 1'b1, 6'($urandom), 1'b1);
    drain();
    check("erase_count", 32'(out_log.size()), 32'd1);
    check("erase_flag", 32'(out_log[0][16]), 32'd1);
    check("erase_bm", 32'(out_log[0][15:0]), 32'd0);

    // Random stream with pseudo-random backpressure and gaps.
    punct_pattern = 4'($urandom);
    out_log.delete();
    start = n_acc;
    for (int c = 0; c < 400 && (n_acc - start) < 24; c++) begin
      step(1'(($urandom % 4) != 0), 1'(($urandom % 6) == 0), 6'($urandom), 1'($urandom % 2));
    end
    drain();
    check("bp_accepted", 32'(n_acc - start), 32'd24);
    check("bp_outputs", 32'(out_log.size()), 32'd24);

    // Reset with two symbols in flight and the phase counter at 1.
    punct_pattern = {2'b01, 2'b11};
    step(1'b1, 1'b0, SYM, 1'b0);
    step(1'b1, 1'b1, SYM, 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    ph_m = 0;
    stall_prev = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_bm", 32'(bm), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_log.delete();
    step(1'b1, 1'b0, SYM, 1'b1);
    drain();
    check("mid_rst_count", 32'(out_log.size()), 32'd1);
    check("mid_rst_phase0", 32'(out_log[0][15:0]), 32'h70E7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
